// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: KMP-style state machine whose transition
// table is built from PATTERN/N at elaboration, with Mealy match flag and saturating counter.
module seq_detect_param #(
    parameter int         N       = 5,
    parameter logic [N-1:0] PATTERN = 5'b11011,
    parameter bit         OVERLAP = 1'b1,
    parameter int         CNT_W   = 8,
    localparam int        SW      = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             clear_cnt,
    output logic             out,
    output logic             match_q,
    output logic [SW-1:0]    present,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int TBL_SZ = 2 ** (SW + 1);

    function automatic logic pbit(input int p);
        logic [N-1:0] t;
        t = PATTERN >> p;
        return t[0];
    endfunction

    function automatic logic sbit(input logic [31:0] s, input int p);
        logic [31:0] t;
        t = s >> p;
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length k followed by b);
    // lengths are capped below N so a full match falls back to the longest border.
    function automatic logic [SW-1:0] next_of(input int k, input int b);
        logic [31:0] s;
        int          best;
        logic        ok;
        s    = 32'(b) << k;
        best = 0;
        for (int j = 0; j < 16; j++) begin
            if (j < k) begin
                s = s | (32'(pbit(N - 1 - j)) << j);
            end
        end
        if ((OVERLAP == 1'b0) && (k == N - 1) && (b == int'(pbit(0)))) begin
            return '0;
        end
        for (int l = 1; l < 17; l++) begin
            if ((l <= k + 1) && (l < N)) begin
                ok = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (i < l) begin
                        if (sbit(s, k + 1 - l + i) != pbit(N - 1 - i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return SW'(best);
    endfunction

    logic [SW-1:0]    w_tbl [TBL_SZ];
    logic [SW-1:0]    w_next;
    logic             w_out;
    logic [SW-1:0]    r_present;
    logic             r_match_q;
    logic [CNT_W-1:0] r_cnt;

    // Table is indexed by {state, bit}; rows for states >= N decode to state 0.
    for (genvar g = 0; g < TBL_SZ; g++) begin : g_tbl
        if ((g / 2) < N) begin : g_legal
            assign w_tbl[g] = next_of(g / 2, g % 2);
        end else begin : g_illegal
            assign w_tbl[g] = '0;
        end
    end

    // Next-state lookup and Mealy match flag.
    always_comb begin
        w_next = w_tbl[{r_present, in}];
        if (!reset && in_valid && (r_present == SW'(N - 1)) && (in == PATTERN[0])) begin
            w_out = 1'b1;
        end else begin
            w_out = 1'b0;
        end
    end

    // State, delayed match flag and saturating match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_present <= '0;
            r_match_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_match_q <= w_out;
            if (in_valid) begin
                r_present <= w_next;
            end else begin
                r_present <= r_present;
            end
            if (clear_cnt) begin
                r_cnt <= '0;
            end else if (w_out && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign out       = w_out;
    assign match_q   = r_match_q;
    assign present   = r_present;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: several parameterisations share one input stream,
// each scenario checks the instance it targets against hand-derived values.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in = 1'b0;
    logic clear_cnt = 1'b0;

    logic       d_out, d_q, no_out, no_q, c2_out, c2_q, p3_out, p3_q, p3n_out, p3n_q;
    logic [2:0] d_pres, no_pres, c2_pres;
    logic [1:0] p3_pres, p3n_pres;
    logic [7:0] d_cnt, no_cnt, p3_cnt, p3n_cnt;
    logic [1:0] c2_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param u_d (.clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .clear_cnt(clear_cnt), .out(d_out), .match_q(d_q), .present(d_pres), .match_cnt(d_cnt));

    seq_detect_param #(.OVERLAP(1'b0)) u_no (.clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .clear_cnt(clear_cnt), .out(no_out), .match_q(no_q), .present(no_pres), .match_cnt(no_cnt));

    seq_detect_param #(.CNT_W(2)) u_c2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .clear_cnt(clear_cnt), .out(c2_out), .match_q(c2_q), .present(c2_pres), .match_cnt(c2_cnt));

    seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1)) u_p3 (.clk(clk), .reset(reset),
        .in_valid(in_valid), .in(in), .clear_cnt(clear_cnt), .out(p3_out), .match_q(p3_q),
        .present(p3_pres), .match_cnt(p3_cnt));

    seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u_p3n (.clk(clk), .reset(reset),
        .in_valid(in_valid), .in(in), .clear_cnt(clear_cnt), .out(p3n_out), .match_q(p3n_q),
        .present(p3n_pres), .match_cnt(p3n_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid  = v;
        in        = b;
        clear_cnt = c;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in        = 1'b0;
        clear_cnt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] bits8, exp_d8, exp_no8;
    logic [5:0] bits6, exp_o6;
    logic [4:0] bits5, exp_p3o, exp_p3no;
    int         exp_p[6];
    int         exp_c[5];

    initial begin
        // Reset state
        do_reset();
        chk("rst_present", 32'(d_pres), 32'd0);
        chk("rst_match_q", 32'(d_q), 32'd0);
        chk("rst_cnt", 32'(d_cnt), 32'd0);
        chk("rst_cnt_c2", 32'(c2_cnt), 32'd0);

        // Overlap vs non-overlap on 1,1,0,1,1,0,1,1
        bits8   = 8'b11011011;
        exp_d8  = 8'b00001001;
        exp_no8 = 8'b00001000;
        for (int i = 0; i < 8; i++) begin
            put(1'b1, bits8[7-i], 1'b0);
            chk($sformatf("ovl_out_bit%0d", i + 1), 32'(d_out), 32'(exp_d8[7-i]));
            chk($sformatf("novl_out_bit%0d", i + 1), 32'(no_out), 32'(exp_no8[7-i]));
            if (i == 5) begin
                chk("first_match_q", 32'(d_q), 32'd1);
                chk("first_match_cnt", 32'(d_cnt), 32'd1);
                chk("after_match_present", 32'(d_pres), 32'd2);
                chk("novl_after_match_present", 32'(no_pres), 32'd0);
            end
        end
        put(1'b0, 1'b0, 1'b0);
        chk("ovl_cnt", 32'(d_cnt), 32'd2);
        chk("novl_cnt", 32'(no_cnt), 32'd1);
        chk("c2_cnt_two", 32'(c2_cnt), 32'd2);
        chk("ovl_match_q_bit8", 32'(d_q), 32'd1);
        chk("novl_match_q_bit8", 32'(no_q), 32'd0);

        // Extra leading 1 absorbed: 1,1,1,0,1,1
        do_reset();
        bits6 = 6'b111011;
        exp_o6 = 6'b000001;
        exp_p = '{0, 1, 2, 2, 3, 4};
        for (int i = 0; i < 6; i++) begin
            put(1'b1, bits6[5-i], 1'b0);
            chk($sformatf("absorb_present_%0d", i), 32'(d_pres), 32'(exp_p[i]));
            chk($sformatf("absorb_out_%0d", i), 32'(d_out), 32'(exp_o6[5-i]));
        end

        // in_valid gap holds state and gates out
        do_reset();
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            put(1'b0, 1'b1, 1'b0);
            chk($sformatf("gap_present_%0d", i), 32'(d_pres), 32'd3);
            chk($sformatf("gap_out_%0d", i), 32'(d_out), 32'd0);
        end
        put(1'b1, 1'b1, 1'b0);
        chk("gap_resume_present", 32'(d_pres), 32'd3);
        put(1'b0, 1'b1, 1'b0);
        chk("gap_at4_present", 32'(d_pres), 32'd4);
        chk("gap_at4_out", 32'(d_out), 32'd0);
        put(1'b1, 1'b1, 1'b0);
        chk("gap_match_out", 32'(d_out), 32'd1);
        put(1'b0, 1'b0, 1'b0);
        chk("gap_match_cnt", 32'(d_cnt), 32'd1);

        // Saturation with CNT_W=2, then clear_cnt on a match cycle
        do_reset();
        exp_c = '{1, 2, 3, 3, 3};
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        for (int m = 0; m < 4; m++) begin
            put(1'b1, 1'b0, 1'b0);
            chk($sformatf("sat_cnt_%0d", m + 1), 32'(c2_cnt), 32'(exp_c[m]));
            put(1'b1, 1'b1, 1'b0);
            put(1'b1, 1'b1, 1'b0);
        end
        put(1'b1, 1'b0, 1'b0);
        chk("sat_cnt_5", 32'(c2_cnt), 32'(exp_c[4]));
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b1);
        chk("clr_match_out", 32'(c2_out), 32'd1);
        put(1'b0, 1'b0, 1'b0);
        chk("clr_cnt_zero", 32'(c2_cnt), 32'd0);
        chk("clr_match_q", 32'(c2_q), 32'd1);
        chk("clr_present", 32'(c2_pres), 32'd2);
        chk("clr_cnt_default", 32'(d_cnt), 32'd0);

        // Reset mid-pattern discards the partial match
        do_reset();
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b0, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        in = 1'b1;
        #1;
        chk("rst_forces_out0", 32'(d_out), 32'd0);
        chk("rst_pre_edge_present", 32'(d_pres), 32'd4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_present", 32'(d_pres), 32'd0);
        chk("rst_mid_out", 32'(d_out), 32'd0);
        put(1'b0, 1'b0, 1'b0);
        chk("rst_mid_restart", 32'(d_pres), 32'd1);
        chk("rst_mid_cnt", 32'(d_cnt), 32'd0);

        // N=3, PATTERN=101 on 1,0,1,0,1
        do_reset();
        bits5    = 5'b10101;
        exp_p3o  = 5'b00101;
        exp_p3no = 5'b00100;
        for (int i = 0; i < 5; i++) begin
            put(1'b1, bits5[4-i], 1'b0);
            chk($sformatf("p3_ovl_out_%0d", i + 1), 32'(p3_out), 32'(exp_p3o[4-i]));
            chk($sformatf("p3_novl_out_%0d", i + 1), 32'(p3n_out), 32'(exp_p3no[4-i]));
        end
        put(1'b0, 1'b0, 1'b0);
        chk("p3_ovl_cnt", 32'(p3_cnt), 32'd2);
        chk("p3_novl_cnt", 32'(p3n_cnt), 32'd1);
        chk("p3_ovl_present", 32'(p3_pres), 32'd1);
        chk("p3_novl_present", 32'(p3n_pres), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
